// File: rtl/vid_timing_pkg.sv
// -----------------------------------------------------------------------------
// vid_timing_pkg
// Shared constants and helpers for the raster timing generator.
//   - DEF_* : the default 640x480@60 mode (25 MHz pixel rate from 50 MHz)
//   - vid_total()    : sum of active + porches + sync for one axis
//   - vid_width_ok() : true when a counter of width w can hold 0..total-1
// -----------------------------------------------------------------------------
package vid_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam int DEF_CE_DIV   = 2;
    localparam int DEF_XW       = 10;
    localparam int DEF_YW       = 10;

    function automatic int vid_total(input int active, input int fp,
                                     input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic bit vid_width_ok(input int total, input int w);
        return (w >= $clog2(total));
    endfunction

endpackage

// File: rtl/vid_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vid_timing_gen_if
// Bundle of raster timing outputs.
//   master : driven by vid_timing_gen
//   slave  : consumed by the video pipeline / scan-out logic
// Signals: ce_pix, hs, vs, de, hblank, vblank, x[XW], y[YW],
//          line_start, frame_start
// -----------------------------------------------------------------------------
interface vid_timing_gen_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          ce_pix;
    logic          hs;
    logic          vs;
    logic          de;
    logic          hblank;
    logic          vblank;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output ce_pix, hs, vs, de, hblank, vblank, x, y, line_start, frame_start
    );

    modport slave (
        input ce_pix, hs, vs, de, hblank, vblank, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vid_ce_div.sv
// -----------------------------------------------------------------------------
// vid_ce_div
// Pixel clock-enable divider. ce_cnt runs 0..CE_DIV-1; ce_pix is a registered
// one-clk pulse on each wrap (continuously high when CE_DIV = 1).
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   enable in  count when high; counter and ce_pix cleared at next edge when low
//   ce_pix out pixel clock-enable
// -----------------------------------------------------------------------------
module vid_ce_div #(
    parameter int CE_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic ce_pix
);

    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CE_DIV - 1);

    logic [CW-1:0] ce_cnt_q, ce_cnt_d;
    logic          ce_pix_q, ce_pix_d;

    always_comb begin
        ce_cnt_d = ce_cnt_q;
        ce_pix_d = 1'b0;
        if (!enable) begin
            ce_cnt_d = '0;
        end else if (ce_cnt_q == CNT_LAST) begin
            // With CE_DIV = 1 the counter sits at 0 and this fires every cycle.
            ce_cnt_d = '0;
            ce_pix_d = 1'b1;
        end else begin
            ce_cnt_d = ce_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_cnt_q <= '0;
            ce_pix_q <= 1'b0;
        end else begin
            ce_cnt_q <= ce_cnt_d;
            ce_pix_q <= ce_pix_d;
        end
    end

    assign ce_pix = ce_pix_q;

endmodule

// File: rtl/vid_timing_gen.sv
// -----------------------------------------------------------------------------
// vid_timing_gen
// Parametrised raster timing generator. Derives ce_pix from clk and produces
// x/y counters plus registered sync, blanking, data-enable and strobes.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset (enters restart state)
//   enable in  run when high; restart state at next edge when low
//   vif    vid_timing_gen_if.master : ce_pix, hs, vs, de, hblank, vblank,
//                                     x, y, line_start, frame_start
// Restart state is (H_TOTAL-1, V_TOTAL-1) so the first pixel enable lands the
// raster on (0,0) and fires both start strobes.
// -----------------------------------------------------------------------------
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int CE_DIV   = DEF_CE_DIV,
    parameter int XW       = DEF_XW,
    parameter int YW       = DEF_YW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    vid_timing_gen_if.master vif
);

    localparam int H_TOTAL = vid_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vid_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_SYNC == 0 || V_SYNC == 0 || CE_DIV == 0) begin : g_bad_mode
        $error("vid_timing_gen: H_ACTIVE, V_ACTIVE, H_SYNC, V_SYNC and CE_DIV must be non-zero");
    end
    if (!vid_width_ok(H_TOTAL, XW) || !vid_width_ok(V_TOTAL, YW)) begin : g_bad_width
        $error("vid_timing_gen: XW/YW too narrow for H_TOTAL/V_TOTAL");
    end

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);

    // Decode bounds carry one extra bit: with a zero back porch the sync end
    // equals the total, which may be exactly 2**XW.
    localparam logic [XW:0] H_ACT_END = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] HS_BEG    = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] HS_END    = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] V_ACT_END = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] VS_BEG    = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] VS_END    = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic ce_pix;

    vid_ce_div #(
        .CE_DIV (CE_DIV)
    ) u_ce_div (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .ce_pix (ce_pix)
    );

    logic [XW-1:0] x_q, x_d, x_nxt;
    logic [YW-1:0] y_q, y_d, y_nxt;
    logic          de_q, de_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    always_comb begin
        x_nxt         = x_q;
        y_nxt         = y_q;
        x_d           = x_q;
        y_d           = y_q;
        de_d          = de_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (!enable) begin
            // Restart outputs are forced rather than decoded so they stay
            // inactive even when a zero back porch puts H_TOTAL-1 in sync.
            x_d      = X_LAST;
            y_d      = Y_LAST;
            de_d     = 1'b0;
            hblank_d = 1'b1;
            vblank_d = 1'b1;
            hs_d     = ~HS_POL;
            vs_d     = ~VS_POL;
        end else if (ce_pix) begin
            if (x_q == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_nxt = x_q + 1'b1;
            end

            // Decode from the next count so outputs move on the same edge as x/y.
            // vs depends only on y, which changes only when x wraps to 0.
            x_d           = x_nxt;
            y_d           = y_nxt;
            hblank_d      = ({1'b0, x_nxt} >= H_ACT_END);
            vblank_d      = ({1'b0, y_nxt} >= V_ACT_END);
            de_d          = ({1'b0, x_nxt} <  H_ACT_END) && ({1'b0, y_nxt} < V_ACT_END);
            hs_d          = (({1'b0, x_nxt} >= HS_BEG) && ({1'b0, x_nxt} < HS_END)) ? HS_POL : ~HS_POL;
            vs_d          = (({1'b0, y_nxt} >= VS_BEG) && ({1'b0, y_nxt} < VS_END)) ? VS_POL : ~VS_POL;
            line_start_d  = (x_nxt == '0);
            frame_start_d = (x_nxt == '0) && (y_nxt == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            de_q          <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.ce_pix      = ce_pix;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.de          = de_q;
    assign vif.hblank      = hblank_q;
    assign vif.vblank      = vblank_q;
    assign vif.hs          = hs_q;
    assign vif.vs          = vs_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;

endmodule
